// File: rtl/multiplier_pkg.sv
// Shared constants and types for the multiplier input-conditioning path.
// Holds the factor width, the debounce FSM state encoding and the default
// settle window derived from the 2500 Hz board clock.
package multiplier_pkg;

    localparam int FACTOR_W  = 3;
    localparam int PAIR_W    = 2 * FACTOR_W;

    // 2500 Hz board clock, 10 ms settle window -> 25 cycles.
    localparam int CLK_HZ    = 2500;
    localparam int SETTLE_MS = 10;
    localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ * SETTLE_MS) / 1000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PRESENT = 2'd2
    } deb_state_t;

endpackage

// File: rtl/factor_debouncer_bit_synchronizer.sv
// Multi-flop synchroniser for a bus of independent asynchronous bits.
// Every bit gets SYNC_STAGES flops; all flops clear on the async active-low reset.
module bit_synchronizer #(
    parameter int WIDTH       = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [SYNC_STAGES];

    // Shift the raw bits through the synchroniser chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/factor_debouncer.sv
// Synchronises and debounces the two 3-bit factor switch banks and presents
// each newly settled pair once on a valid/ready handshake.
// Optional build macro: DEBOUNCE_STATUS_EN adds the o_bounce_cnt status port.
//
// Handshake: o_valid rises when a new settled pair is loaded into
// o_factor_a/o_factor_b; the pair and o_valid stay frozen until a cycle in
// which i_ready is sampled high, after which o_valid is low. i_ready has no
// effect while o_valid is low.
module factor_debouncer
    import multiplier_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [FACTOR_W-1:0] i_factor_a,
    input  logic [FACTOR_W-1:0] i_factor_b,
    input  logic                i_ready,
    output logic [FACTOR_W-1:0] o_factor_a,
    output logic [FACTOR_W-1:0] o_factor_b,
    output logic                o_valid,
    output logic                o_busy,
`ifdef DEBOUNCE_STATUS_EN
    output logic [3:0]          o_bounce_cnt,
`endif
    output deb_state_t          o_dbg_state
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [PAIR_W-1:0] w_synced;
    deb_state_t        r_state;
    deb_state_t        w_state_n;
    logic [PAIR_W-1:0] r_cand;
    logic [PAIR_W-1:0] w_cand_n;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_n;
    logic [PAIR_W-1:0] r_out;
    logic [PAIR_W-1:0] w_out_n;

    bit_synchronizer #(
        .WIDTH       (PAIR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   ({i_factor_a, i_factor_b}),
        .o_q   (w_synced)
    );

    // Register the FSM state, candidate, settle counter and presented pair.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cand  <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cand  <= w_cand_n;
            r_cnt   <= w_cnt_n;
            r_out   <= w_out_n;
        end
    end

    // Next-state logic: detect change, wait for a full stable window, present once.
    always_comb begin
        w_state_n = r_state;
        w_cand_n  = r_cand;
        w_cnt_n   = r_cnt;
        w_out_n   = r_out;
        case (r_state)
            IDLE: begin
                if (w_synced != r_out) begin
                    w_cand_n  = w_synced;
                    w_cnt_n   = '0;
                    w_state_n = SETTLE;
                end
            end
            SETTLE: begin
                // A change on the final count cycle still restarts the window.
                if (w_synced != r_cand) begin
                    w_cand_n = w_synced;
                    w_cnt_n  = '0;
                end else if (r_cnt == CNT_LAST) begin
                    if (r_cand != r_out) begin
                        w_out_n   = r_cand;
                        w_state_n = PRESENT;
                    end else begin
                        // Switches bounced back to the pair already presented.
                        w_state_n = IDLE;
                    end
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            PRESENT: begin
                // Input changes are ignored here and picked up from IDLE later.
                if (i_ready) begin
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

`ifdef DEBOUNCE_STATUS_EN
    logic       w_bounce;
    logic [3:0] r_bounce_cnt;

    assign w_bounce = (r_state == SETTLE) &&
                      ((w_synced != r_cand) ||
                       ((r_cnt == CNT_LAST) && (r_cand == r_out)));

    // Count restarts and bounce-back exits, saturating at 15.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bounce_cnt <= '0;
        end else if (w_bounce && (r_bounce_cnt != 4'hF)) begin
            r_bounce_cnt <= r_bounce_cnt + 4'd1;
        end
    end

    assign o_bounce_cnt = r_bounce_cnt;
`endif

    assign o_factor_a  = r_out[PAIR_W-1:FACTOR_W];
    assign o_factor_b  = r_out[FACTOR_W-1:0];
    assign o_valid     = (r_state == PRESENT);
    assign o_busy      = (r_state == SETTLE);
    assign o_dbg_state = r_state;

endmodule
